// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and helpers for the FIFO write-side arbiter
//   arb_state_t : arbiter FSM states (IDLE = free to grant, BURST = packet owns grant)
//   pack_beat   : builds the {src_id, last, payload} word written into the FIFO
package fifo_arb_pkg;

    typedef enum logic [0:0] {IDLE, BURST} arb_state_t;

    // Widest packed beat the helper can build; callers truncate to their own width.
    localparam int PACK_MAX = 1024;

    function automatic logic [PACK_MAX-1:0] pack_beat(
        input logic [PACK_MAX-1:0] id,
        input logic                last,
        input logic [PACK_MAX-1:0] data,
        input int                  width
    );
        return (id << (width + 1)) | (PACK_MAX'(last) << width) | data;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker
//   req : request vector
//   ptr : index where the search starts (must be < N)
//   any : at least one request is set
//   idx : first set request at or above ptr, wrapping past N-1 to 0
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] j;

    // Scan from the farthest candidate back to ptr so the nearest one wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        j   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((32'(ptr) + k) % N);
            if (req[j]) begin
                any = 1'b1;
                idx = j;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, packet-locked sharing of one sync_fifo write port
//   wclk, rst     : clock, asynchronous active-high reset
//   req_valid     : per-lane beat valid
//   req_last      : per-lane end-of-packet, qualified by req_valid
//   req_data      : per-lane payload, lane i at [i*WIDTH +: WIDTH]
//   req_ready     : per-lane accept, one-hot or zero
//   fifo_w_en     : FIFO write strobe
//   fifo_w_data   : {src_id, last, payload}, held when not writing
//   fifo_full     : FIFO full flag (only ever used registered)
//   busy          : a packet currently owns the grant
//   beat_cnt      : wrapping count of beats written since reset
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int WIDTH     = 32,
    parameter  int BURST_MAX = 8,
    localparam int IDW       = $clog2(N_REQ)
) (
    input  logic                   wclk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ-1:0]       req_last,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   fifo_w_en,
    output logic [WIDTH+IDW:0]     fifo_w_data,
    input  logic                   fifo_full,
    output logic                   busy,
    output logic [31:0]            beat_cnt
);

    localparam int FW = WIDTH + IDW + 1;

    arb_state_t     state, state_n;
    logic [IDW-1:0] rr_ptr, rr_n, owner, owner_n, pick, sel;
    logic [7:0]     burst_cnt, cnt_n;
    logic [FW-1:0]  data_q, data_n;
    logic [WIDTH-1:0] lane_data;
    logic           any, full_q, grant, xfer, burst_end;

    function automatic logic [IDW-1:0] nxt(input logic [IDW-1:0] i);
        return (32'(i) == N_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    rr_pick #(.N(N_REQ)) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .any (any),
        .idx (pick)
    );

    // Datapath and handshake. fifo_full reaches the grant only through full_q,
    // because the FIFO's own full depends on fifo_w_en and would form a loop.
    // The grant is also held off while rst is asserted so nothing is accepted
    // during an asynchronous reset.
    always_comb begin
        sel         = (state == BURST) ? owner : pick;
        grant       = !rst && !full_q && (state == BURST || any);
        xfer        = grant && req_valid[sel];
        req_ready   = grant ? (N_REQ'(1) << sel) : '0;
        lane_data   = req_data[sel*WIDTH +: WIDTH];
        data_n      = FW'(pack_beat(PACK_MAX'(sel), req_last[sel], PACK_MAX'(lane_data), WIDTH));
        fifo_w_en   = xfer;
        fifo_w_data = xfer ? data_n : data_q;
        busy        = (state == BURST);
        burst_end   = req_last[sel] || ({1'b0, burst_cnt} + 9'd1 == 9'(BURST_MAX));
    end

    // Next state: nothing moves without a transfer, so full_q and an idle owner
    // both freeze the FSM, pointer and burst count.
    always_comb begin
        state_n = state;
        rr_n    = rr_ptr;
        owner_n = owner;
        cnt_n   = burst_cnt;
        if (xfer && state == IDLE) begin
            if (req_last[sel] || BURST_MAX == 1) begin
                rr_n = nxt(sel);
            end else begin
                owner_n = sel;
                cnt_n   = 8'd1;
                state_n = BURST;
            end
        end else if (xfer) begin
            if (burst_end) begin
                state_n = IDLE;
                rr_n    = nxt(owner);
                cnt_n   = '0;
            end else begin
                cnt_n   = burst_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            burst_cnt <= '0;
            full_q    <= 1'b0;
            data_q    <= '0;
            beat_cnt  <= '0;
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_n;
            owner     <= owner_n;
            burst_cnt <= cnt_n;
            full_q    <= fifo_full;
            if (xfer) begin
                data_q   <= data_n;
                beat_cnt <= beat_cnt + 32'd1;
            end
        end
    end

endmodule
